chdr_traffic_source: RTL and testbench

Synthesizable CHDR (CVITA, 64-bit) traffic generator for crossbar load-latency characterization. On a start strobe it injects a configured number of fixed-size packets at a programmable injection rate. Destinations follow a selectable traffic pattern. Each packet is stamped with its generation time and carries an incrementing payload, so a downstream traffic sink can check integrity, routing and latency.

---
 rtl/chdr_traffic_source.sv | 230 +++++++++++++++++++++++
 tb/tb_chdr_traffic_source.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chdr_traffic_source.sv
// CHDR (CVITA, 64-bit) traffic source. Injects fixed-size timestamped packets
// at a programmable offered load, with destinations chosen by a traffic pattern.
module chdr_traffic_source #(
    parameter int          WIDTH     = 64,
    parameter int          MTU       = 5,
    parameter logic [15:0] NODE_ID   = 16'd0,
    parameter logic [15:0] NUM_NODES = 16'd16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      current_time,
    input  logic             start_stb,
    input  logic [7:0]       injection_rate,
    input  logic [15:0]      lines_per_pkt,
    input  logic [7:0]       traffic_patt,
    input  logic [31:0]      num_pkts_to_xfer,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             session_active,
    output logic [31:0]      xfer_count,
    output logic [31:0]      pkt_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_HDR, S_TS, S_PAY, S_DONE
    } state_t;

    localparam int          NB          = $clog2(NUM_NODES);
    localparam logic [15:0] DST_MASK    = 16'((32'd1 << NB) - 32'd1);
    localparam logic [15:0] DST_NEXT    = 16'((32'(NODE_ID) + 32'd1) % 32'(NUM_NODES));
    localparam logic [15:0] DST_TORNADO = NUM_NODES - 16'd1 - NODE_ID;
    localparam logic [15:0] MAX_LEN     = 16'(32'd1 << MTU);

    state_t      state_q, state_d;
    logic [6:0]  rate_q, rate_d;
    logic [15:0] len_q, len_d;
    logic [31:0] thresh_q, thresh_d;
    logic [7:0]  patt_q, patt_d;
    logic [31:0] num_q, num_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [11:0] seq_q, seq_d;
    logic [63:0] ts_q, ts_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] word_q, word_d;
    logic [31:0] xfer_q, xfer_d;
    logic [31:0] pkt_q, pkt_d;

    logic [32:0] acc_sum;
    logic [31:0] acc_inc;
    logic        can_start;
    logic        go_pkt;
    logic        fire;
    logic [15:0] rnd_m;
    logic [15:0] dst_pick;
    logic [15:0] lfsr_next;
    logic [15:0] len_in;

    // Outputs decode from registered state only, so tready never reaches tvalid
    assign m_axis_tvalid  = (state_q == S_HDR) || (state_q == S_TS) || (state_q == S_PAY);
    assign session_active = m_axis_tvalid || (state_q == S_WAIT);
    assign xfer_count     = xfer_q;
    assign pkt_count      = pkt_q;
    assign fire           = m_axis_tvalid && m_axis_tready;

    // Line mux for the current beat
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tlast = 1'b0;
        case (state_q)
            S_HDR: m_axis_tdata = {2'b00, 1'b1, 1'b0, seq_q, len_q[12:0], 3'b000, NODE_ID, dst_q};
            S_TS: begin
                m_axis_tdata = ts_q;
                m_axis_tlast = (len_q == 16'd2);
            end
            S_PAY: begin
                m_axis_tdata = {48'd0, word_q};
                m_axis_tlast = (word_q == len_q - 16'd3);
            end
            default: ;
        endcase
    end

    // Credit arithmetic, destination selection and LFSR step
    always_comb begin
        acc_sum   = {1'b0, acc_q} + {26'd0, rate_q};
        acc_inc   = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
        can_start = (acc_inc >= thresh_q);
        rnd_m     = lfsr_q & DST_MASK;
        lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        len_in    = (lines_per_pkt < 16'd2)  ? 16'd2 :
                    (lines_per_pkt > MAX_LEN) ? MAX_LEN : lines_per_pkt;
        case (traffic_patt_sel(patt_q))
            2'd1:    dst_pick = (rnd_m >= NUM_NODES) ? rnd_m - NUM_NODES : rnd_m;
            2'd2:    dst_pick = DST_NEXT;
            2'd3:    dst_pick = DST_TORNADO;
            default: dst_pick = NODE_ID;
        endcase
    end

    function automatic logic [1:0] traffic_patt_sel(input logic [7:0] p);
        case (p)
            8'h55:   return 2'd1;  // 'U' uniform random
            8'h4E:   return 2'd2;  // 'N' neighbour
            8'h54:   return 2'd3;  // 'T' tornado
            default: return 2'd0;  // 'L' loopback and anything else
        endcase
    endfunction

    // Session / packet FSM next state
    always_comb begin
        state_d  = state_q;
        rate_d   = rate_q;
        len_d    = len_q;
        thresh_d = thresh_q;
        patt_d   = patt_q;
        num_d    = num_q;
        acc_d    = acc_q;
        lfsr_d   = lfsr_q;
        seq_d    = seq_q;
        ts_d     = ts_q;
        dst_d    = dst_q;
        word_d   = word_q;
        xfer_d   = fire ? xfer_q + 32'd1 : xfer_q;
        pkt_d    = pkt_q;
        go_pkt   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_stb) begin
                    rate_d   = (injection_rate > 8'd100) ? 7'd100 : injection_rate[6:0];
                    len_d    = len_in;
                    thresh_d = {16'd0, len_in} * 32'd100;
                    patt_d   = traffic_patt;
                    num_d    = num_pkts_to_xfer;
                    acc_d    = '0;
                    lfsr_d   = LFSR_SEED;
                    seq_d    = '0;
                    xfer_d   = '0;
                    pkt_d    = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (num_q == 32'd0) begin
                    state_d = S_DONE;
                end else begin
                    acc_d  = acc_inc;
                    go_pkt = can_start;
                end
            end
            S_HDR: begin
                acc_d = acc_inc;
                if (fire) state_d = S_TS;
            end
            S_TS, S_PAY: begin
                // Credit keeps accruing during the packet so offered load is
                // measured against all bus cycles, not just idle ones.
                acc_d = acc_inc;
                if (fire) begin
                    if (m_axis_tlast) begin
                        pkt_d = pkt_q + 32'd1;
                        seq_d = seq_q + 12'd1;
                        if (pkt_q + 32'd1 == num_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_WAIT;
                            go_pkt  = can_start;  // chain straight into the next header
                        end
                    end else if (state_q == S_TS) begin
                        state_d = S_PAY;
                        word_d  = '0;
                    end else begin
                        word_d = word_q + 16'd1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (go_pkt) begin
            acc_d   = acc_inc - thresh_q;
            ts_d    = current_time;
            dst_d   = dst_pick;
            lfsr_d  = lfsr_next;
            word_d  = '0;
            state_d = S_HDR;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rate_q   <= '0;
            len_q    <= '0;
            thresh_q <= '0;
            patt_q   <= '0;
            num_q    <= '0;
            acc_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            seq_q    <= '0;
            ts_q     <= '0;
            dst_q    <= '0;
            word_q   <= '0;
            xfer_q   <= '0;
            pkt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rate_q   <= rate_d;
            len_q    <= len_d;
            thresh_q <= thresh_d;
            patt_q   <= patt_d;
            num_q    <= num_d;
            acc_q    <= acc_d;
            lfsr_q   <= lfsr_d;
            seq_q    <= seq_d;
            ts_q     <= ts_d;
            dst_q    <= dst_d;
            word_q   <= word_d;
            xfer_q   <= xfer_d;
            pkt_q    <= pkt_d;
        end
    end

endmodule

// File: tb/tb_chdr_traffic_source.sv
// Scoreboard bench for chdr_traffic_source (NODE_ID=5, NUM_NODES=16, MTU=5).
module tb_chdr_traffic_source;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] current_time = 64'h0000_1000_0000_0000;
    logic        start_stb = 1'b0;
    logic [7:0]  injection_rate = 8'd0;
    logic [15:0] lines_per_pkt = 16'd0;
    logic [7:0]  traffic_patt = 8'h4C;
    logic [31:0] num_pkts_to_xfer = 32'd0;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        session_active;
    logic [31:0] xfer_count;
    logic [31:0] pkt_count;

    always #5 clk = ~clk;
    always @(posedge clk) current_time <= current_time + 64'd1;

    chdr_traffic_source #(
        .WIDTH(64), .MTU(5), .NODE_ID(16'd5), .NUM_NODES(16'd16), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .current_time(current_time), .start_stb(start_stb),
        .injection_rate(injection_rate), .lines_per_pkt(lines_per_pkt),
        .traffic_patt(traffic_patt), .num_pkts_to_xfer(num_pkts_to_xfer),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .session_active(session_active), .xfer_count(xfer_count), .pkt_count(pkt_count)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        is_hdr;
        logic        is_ts;
    } beat_t;

    beat_t       sb[$];
    logic [63:0] hdr_times[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] dst_seen;
    logic [15:0] lfsr_m;
    logic        bp_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input longint act, input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Expected lines of one packet; the timestamp line is checked by the monitor
    task automatic push_pkt(input int seq, input logic [15:0] dst, input int len);
        beat_t b;
        b.data = {2'b00, 1'b1, 1'b0, 12'(seq), 16'(len * 8), 16'd5, dst};
        b.last = 1'b0; b.is_hdr = 1'b1; b.is_ts = 1'b0;
        sb.push_back(b);
        b.data = '0; b.last = (len == 2); b.is_hdr = 1'b0; b.is_ts = 1'b1;
        sb.push_back(b);
        for (int k = 0; k < len - 2; k++) begin
            b.data = 64'(k); b.last = (k == len - 3); b.is_hdr = 1'b0; b.is_ts = 1'b0;
            sb.push_back(b);
        end
    endtask

    task automatic start(input logic [7:0] r, input logic [15:0] l, input logic [7:0] p, input logic [31:0] n);
        @(negedge clk);
        injection_rate = r; lines_per_pkt = l; traffic_patt = p; num_pkts_to_xfer = n;
        start_stb = 1'b1;
        @(negedge clk);
        start_stb = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int c = 0;
        while (session_active && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got still active expected idle within %0d", nm, budget);
        end
        repeat (2) @(negedge clk);
        check({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Random backpressure, changed well away from the sampling edge
    initial forever begin
        @(posedge clk);
        #2 m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability
    initial begin
        logic        stall_prev = 1'b0;
        logic [63:0] hold_data = '0;
        logic        hold_last = 1'b0;
        logic [63:0] prev_ct = '0;
        logic [63:0] hdr_ts = '0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                    check("stall_data", m_axis_tdata, hold_data);
                    check("stall_last", 64'(m_axis_tlast), 64'(hold_last));
                end
                if (m_axis_tvalid && !stall_prev && sb.size() > 0 && sb[0].is_hdr) begin
                    hdr_ts = prev_ct;
                    hdr_times.push_back(current_time);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL extra_beat: got %h expected no beat", m_axis_tdata);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_ts) check("ts_line", m_axis_tdata, hdr_ts);
                        else         check("data_line", m_axis_tdata, e.data);
                        check("tlast", 64'(m_axis_tlast), 64'(e.last));
                        if (e.is_hdr) dst_seen[m_axis_tdata[3:0]] = 1'b1;
                    end
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                hold_data  = m_axis_tdata;
                hold_last  = m_axis_tlast;
            end
            prev_ct = current_time;
        end
    end

    initial begin
        int c;
        int vcnt;
        dst_seen = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_active", 64'(session_active), 64'd0);
        check("rst_xfer", 64'(xfer_count), 64'd0);
        check("rst_pkt", 64'(pkt_count), 64'd0);
        rst = 1'b0;

        // Basic single packet, with an ignored start strobe mid-session
        push_pkt(0, 16'd5, 8);
        start(8'd100, 16'd8, 8'h4C, 32'd1);
        @(negedge clk);
        check("basic_active", 64'(session_active), 64'd1);
        injection_rate = 8'd30; lines_per_pkt = 16'd3; num_pkts_to_xfer = 32'd7; start_stb = 1'b1;
        @(negedge clk);
        start_stb = 1'b0;
        wait_idle("basic", 200);
        check("basic_pkt", 64'(pkt_count), 64'd1);
        check("basic_xfer", 64'(xfer_count), 64'd8);

        // Back-to-back at full rate: 40 consecutive valid cycles
        for (int i = 0; i < 10; i++) push_pkt(i, 16'd5, 4);
        start(8'd100, 16'd4, 8'h4C, 32'd10);
        c = 0;
        while (!m_axis_tvalid && c < 50) begin @(negedge clk); c++; end
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_axis_tvalid) vcnt++;
            @(negedge clk);
        end
        check("b2b_valid_cycles", 64'(vcnt), 64'd40);
        wait_idle("b2b", 200);
        check("b2b_pkt", 64'(pkt_count), 64'd10);
        check("b2b_xfer", 64'(xfer_count), 64'd40);

        // Half rate: average packet spacing 8 cycles
        hdr_times.delete();
        for (int i = 0; i < 10; i++) push_pkt(i, 16'd5, 4);
        start(8'd50, 16'd4, 8'h4C, 32'd10);
        wait_idle("rate50", 400);
        check("rate50_hdrs", 64'(hdr_times.size()), 64'd10);
        if (hdr_times.size() == 10)
            check_range("rate50_span", longint'(hdr_times[9] - hdr_times[0]), 63, 81);

        // Backpressure with neighbour pattern, injection rate above 100 clamps
        for (int i = 0; i < 4; i++) push_pkt(i, 16'd6, 6);
        bp_en = 1'b1;
        start(8'd200, 16'd6, 8'h4E, 32'd4);
        wait_idle("bp", 1000);
        bp_en = 1'b0;
        check("bp_xfer", 64'(xfer_count), 64'd24);

        // Tornado pattern
        for (int i = 0; i < 2; i++) push_pkt(i, 16'd10, 3);
        start(8'd80, 16'd3, 8'h54, 32'd2);
        wait_idle("tornado", 200);

        // Uniform random over 1000 packets
        dst_seen = '0;
        lfsr_m = 16'hACE1;
        for (int i = 0; i < 1000; i++) begin
            push_pkt(i, lfsr_m & 16'h000F, 2);
            lfsr_m = lfsr_step(lfsr_m);
        end
        start(8'd100, 16'd2, 8'h55, 32'd1000);
        wait_idle("uniform", 4000);
        check("uniform_coverage", 64'($countones(dst_seen)), 64'd16);

        // Same seed gives the same sequence in a new session
        lfsr_m = 16'hACE1;
        for (int i = 0; i < 20; i++) begin
            push_pkt(i, lfsr_m & 16'h000F, 5);
            lfsr_m = lfsr_step(lfsr_m);
        end
        start(8'd100, 16'd5, 8'h55, 32'd20);
        wait_idle("reseed", 500);

        // Length clamps
        for (int i = 0; i < 3; i++) push_pkt(i, 16'd5, 2);
        start(8'd100, 16'd0, 8'h4C, 32'd3);
        wait_idle("len_min", 100);
        for (int i = 0; i < 2; i++) push_pkt(i, 16'd5, 32);
        start(8'd100, 16'd100, 8'h4C, 32'd2);
        wait_idle("len_max", 300);
        check("len_max_xfer", 64'(xfer_count), 64'd64);

        // Sequence number wrap
        for (int i = 0; i < 5000; i++) push_pkt(i % 4096, 16'd5, 2);
        start(8'd100, 16'd2, 8'h4C, 32'd5000);
        wait_idle("wrap", 12000);
        check("wrap_pkt", 64'(pkt_count), 64'd5000);
        check("wrap_xfer", 64'(xfer_count), 64'd10000);

        // Zero packets: one WAIT cycle, DONE, then idle
        start(8'd100, 16'd4, 8'h4C, 32'd0);
        check("num0_active_wait", 64'(session_active), 64'd1);
        check("num0_tvalid_wait", 64'(m_axis_tvalid), 64'd0);
        @(negedge clk);
        check("num0_active_done", 64'(session_active), 64'd0);
        check("num0_tvalid_done", 64'(m_axis_tvalid), 64'd0);
        @(negedge clk);
        check("num0_tvalid_idle", 64'(m_axis_tvalid), 64'd0);
        check("num0_pkt", 64'(pkt_count), 64'd0);

        // Reset during payload
        push_pkt(0, 16'd5, 8);
        start(8'd100, 16'd8, 8'h4C, 32'd1);
        c = 0;
        while (xfer_count < 32'd3 && c < 100) begin @(negedge clk); c++; end
        check("rstpay_reached", 64'(xfer_count), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        check("rstpay_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rstpay_active", 64'(session_active), 64'd0);
        check("rstpay_xfer", 64'(xfer_count), 64'd0);
        check("rstpay_pkt", 64'(pkt_count), 64'd0);
        sb.delete();
        rst = 1'b0;
        push_pkt(0, 16'd5, 4);
        start(8'd100, 16'd4, 8'h4C, 32'd1);
        wait_idle("after_rst", 200);
        check("after_rst_pkt", 64'(pkt_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
